uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the 8x-oversampling UART receiver. Captures each byte presented with the receiver's one-cycle ready pulse, stores it in a power-of-two circular buffer, and presents bytes to the host-side consumer over a valid/ready handshake. It also drives the receiver's acknowledge/enable input, which is held low while the buffer is full.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, 2..256.
- `AW`, 4, pointer width; must equal log2(`DEPTH`).
- `clk`, input, 1, system clock; same clock as the receiver.
- `rst_n`, input, 1, reset. One clock; reset is asynchronous and active-low.
- `rx_data`, input, 8, byte from the receiver; valid only in cycles where `rx_rdy` = 1.
- `rx_rdy`, input, 1, one-cycle pulse from the receiver: byte available.
- `rx_ack`, output, 1, receiver enable/acknowledge; 1 = space available.
- `dout`, output, 8, head-of-buffer byte.
- `dout_valid`, output, 1, `dout` holds a valid byte.
- `dout_ready`, input, 1, consumer accepts `dout` this cycle.
- `count`, output, AW+1, number of stored bytes, 0..`DEPTH`.
- `overflow`, output, 1, sticky flag: a byte was dropped. Present only with `RXFIFO_OVF_FLAG_EN`; otherwise tied to 0.
- `ovf_clr`, input, 1, synchronous clear of `overflow`.

## Operation
- Storage: `DEPTH` x 8 array, write pointer `wr_ptr` and read pointer `rd_ptr`, each AW+1 bits.
  - The low AW bits index the array; the MSB is the wrap bit.
  - Pointers wrap modulo 2·`DEPTH` naturally.
- Status flags:
  - `count` = `wr_ptr` − `rd_ptr` (AW+1-bit modular subtraction).
  - `empty` = (`count` == 0).
  - `full` = (`count` == `DEPTH`).
- Write: when `rx_rdy`=1 and (`full`=0 or a read occurs in the same cycle), store `rx_data` at `wr_ptr` and increment `wr_ptr`.
- Read: a read occurs when `dout_valid`=1 and `dout_ready`=1; `rd_ptr` increments.
- Outputs:
  - `dout` = array[`rd_ptr`] (first-word fall-through, combinational from the array).
  - `dout_valid` = !`empty`.
  - `rx_ack` = !`full`.
- Drop: `rx_rdy`=1 while `full`=1 and no read in that cycle → byte is discarded and pointers are unchanged.
- Simultaneous read and write:
  - Both pointers advance; `count` is unchanged.
  - This is legal at `full`: no drop occurs.
- Write to empty: no read is possible in that cycle, because `dout_valid`=0.
- `dout_ready` while `dout_valid`=0: ignored.
- `dout` is undefined while `dout_valid`=0; the verifier must not check it then.
- The block does not inspect parity or framing; every `rx_rdy` pulse is treated as a data byte.

## Timing
- Reset (`rst_n`=0, asynchronous): `wr_ptr`=`rd_ptr`=0 and `overflow`=0.
  - Outputs then read: `count`=0, `dout_valid`=0, `rx_ack`=1.
  - Array contents are not reset.
- Reset mid-operation: all stored bytes are lost immediately. The first `rx_rdy` after `rst_n` rises is accepted normally.
- Write latency: `rx_rdy` sampled at edge N → `dout_valid`=1 and `dout`=byte after edge N, i.e. visible in cycle N+1.
- Read: the handshake at edge N advances `dout` to the next entry after edge N.
- `rx_ack` falls in the cycle after the write that fills the buffer.
  - It rises in the cycle after the first read from full.
  - It is asserted out of reset, which releases the receiver from its post-reset idle state.
- `overflow`: set on the edge following a drop; cleared on an edge with `ovf_clr`=1. If set and clear occur in the same cycle, set wins.
- Throughput: one write and one read per clock, sustained.

## Configuration
- `RXFIFO_OVF_FLAG_EN` defined:
  - The sticky `overflow` register and the `ovf_clr` logic are built.
  - A dropped byte sets `overflow` as specified in Timing.
- Not defined:
  - `overflow` is constant 0.
  - `ovf_clr` is ignored.
  - Drops are still silent and pointers still unchanged; drop behaviour is otherwise identical.

## Test plan
- Reset, then push 0x55 via an `rx_rdy` pulse:
  - Expect `dout_valid`=1, `dout`=0x55 and `count`=1 one cycle later.
  - Pulse `dout_ready` → `count`=0, `dout_valid`=0.
- Fill and drain:
  - Write 0x00..0x0F with `DEPTH`=16 → `count`=16, `rx_ack`=0.
  - Drain with `dout_ready` held 1 → bytes read out in order 0x00..0x0F, `rx_ack`=1 after the first read.
- Overflow (with the macro):
  - At full, push 0xAA → `count` stays 16, `overflow`=1, and the drained data contains no 0xAA.
  - Pulse `ovf_clr` → `overflow`=0.
- Simultaneous read and write at full:
  - Push 0x77 in the same cycle as a read → `count` stays 16 and `overflow` stays 0.
  - Draining all entries ends with 0x77.
- Wrap-around: stream 40 bytes (0x00..0x27) with random `dout_ready` gaps, never exceeding `DEPTH` → all 40 bytes are received in order, and `count` matches a reference model every cycle.
- Asynchronous reset: assert `rst_n`=0 mid-clock with `count`=5 → `count`=0, `dout_valid`=0, `rx_ack`=1 immediately, before the next clock edge.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Receiver-side and consumer-side signal bundle for uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int AW = 4
);
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        rx_ack;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [AW:0] count;
    logic        overflow;
    logic        ovf_clr;

    // master: the environment (receiver + consumer); slave: the buffer itself
    modport master (
        output rx_data, rx_rdy, dout_ready, ovf_clr,
        input  rx_ack, dout, dout_valid, count, overflow
    );

    modport slave (
        input  rx_data, rx_rdy, dout_ready, ovf_clr,
        output rx_ack, dout, dout_valid, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Power-of-two first-word-fall-through byte buffer behind the
//               UART receiver. Optional sticky overflow flag built only when
//               RXFIFO_OVF_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    uart_rx_fifo_if.slave    bus
);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic        w_rd;
    logic        w_wr;
    logic        w_drop;

    // Extra wrap bit on each pointer lets full and empty be told apart.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == c_depth);
    assign w_rd    = !w_empty && bus.dout_ready;
    assign w_wr    = bus.rx_rdy && (!w_full || w_rd);
    assign w_drop  = bus.rx_rdy && w_full && !w_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= bus.rx_data;
    end

    assign bus.dout       = r_mem[r_rd_ptr[AW-1:0]];
    assign bus.dout_valid = !w_empty;
    assign bus.rx_ack     = !w_full;
    assign bus.count      = w_count;

`ifdef RXFIFO_OVF_FLAG_EN
    logic r_overflow;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.overflow = r_overflow;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = bus.ovf_clr | w_drop;
    assign bus.overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo (DEPTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

`ifdef RXFIFO_OVF_FLAG_EN
    localparam int c_ovf_exp = 1;
`else
    localparam int c_ovf_exp = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    int        q[$];
    int        sent;
    int        recvd;
    logic      do_rd;
    logic      do_wr;
    logic [7:0] drain_exp [16];

    uart_rx_fifo_if #(.AW(AW)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        tick();
        bus.rx_rdy  = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n          = 1'b0;
        bus.rx_rdy     = 1'b0;
        bus.rx_data    = 8'h00;
        bus.dout_ready = 1'b0;
        bus.ovf_clr    = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_count", int'(bus.count), 0);
        check("rst_valid", int'(bus.dout_valid), 0);
        check("rst_ack", int'(bus.rx_ack), 1);
        check("rst_ovf", int'(bus.overflow), 0);
        rst_n = 1'b1;
        tick();

        // Single byte in and out
        push(8'h55);
        check("one_valid", int'(bus.dout_valid), 1);
        check("one_data", int'(bus.dout), 8'h55);
        check("one_count", int'(bus.count), 1);
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        check("one_count_after", int'(bus.count), 0);
        check("one_valid_after", int'(bus.dout_valid), 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            check("fill_ack", int'(bus.rx_ack), 1);
            push(8'(i));
        end
        check("full_count", int'(bus.count), 16);
        check("full_ack", int'(bus.rx_ack), 0);
        check("full_head", int'(bus.dout), 8'h00);

        // Drop at full
        push(8'hAA);
        check("drop_count", int'(bus.count), 16);
        check("drop_ovf", int'(bus.overflow), c_ovf_exp);
        check("drop_head", int'(bus.dout), 8'h00);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr", int'(bus.overflow), 0);

        // Simultaneous read and write at full
        bus.rx_rdy     = 1'b1;
        bus.rx_data    = 8'h77;
        bus.dout_ready = 1'b1;
        check("rw_head", int'(bus.dout), 8'h00);
        tick();
        bus.rx_rdy     = 1'b0;
        bus.dout_ready = 1'b0;
        check("rw_count", int'(bus.count), 16);
        check("rw_ovf", int'(bus.overflow), 0);
        check("rw_ack", int'(bus.rx_ack), 0);
        check("rw_head2", int'(bus.dout), 8'h01);

        // Drain: 0x01..0x0F then 0x77, no 0xAA
        for (int i = 0; i < 15; i++) drain_exp[i] = 8'(i + 1);
        drain_exp[15] = 8'h77;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", int'(bus.dout_valid), 1);
            check("drain_data", int'(bus.dout), int'(drain_exp[i]));
            tick();
            if (i == 0) check("drain_ack", int'(bus.rx_ack), 1);
        end
        bus.dout_ready = 1'b0;
        check("drain_count", int'(bus.count), 0);
        check("drain_valid_end", int'(bus.dout_valid), 0);

        // Wrap-around stream with random consumer gaps against a queue model
        sent  = 0;
        recvd = 0;
        for (int cyc = 0; cyc < 400 && recvd < 40; cyc++) begin
            bus.dout_ready = 1'($urandom_range(0, 1));
            do_rd = bus.dout_ready && (q.size() > 0);
            do_wr = (sent < 40) && (q.size() < DEPTH);
            bus.rx_rdy  = do_wr;
            bus.rx_data = 8'(sent);
            if (do_rd) begin
                check("wrap_data", int'(bus.dout), q[0]);
                void'(q.pop_front());
                recvd++;
            end
            if (do_wr) begin
                q.push_back(sent);
                sent++;
            end
            tick();
            check("wrap_count", int'(bus.count), q.size());
        end
        bus.rx_rdy     = 1'b0;
        bus.dout_ready = 1'b0;
        check("wrap_received", recvd, 40);

        // Asynchronous reset mid-clock with five bytes stored
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
        check("pre_rst_count", int'(bus.count), 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", int'(bus.count), 0);
        check("arst_valid", int'(bus.dout_valid), 0);
        check("arst_ack", int'(bus.rx_ack), 1);
        tick();
        rst_n = 1'b1;
        tick();
        push(8'h3C);
        check("post_rst_data", int'(bus.dout), 8'h3C);
        check("post_rst_count", int'(bus.count), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
